// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered WIDTH-bit ALU with Init/Done handshake and iterative shift-add multiply
module alu_seq #(
   parameter int WIDTH = 4
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               Init,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   input  logic [2:0]         Select,
   output logic [2*WIDTH-1:0] Sal,
   output logic               Cout,
   output logic               Zero,
   output logic               Busy,
   output logic               Done
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_OR  = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_SHR = 3'b111;

   logic [1:0]         state;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [CW-1:0]      cnt;

   logic [WIDTH:0]     sum;
   logic [WIDTH-1:0]   res_lo;
   logic               res_c;
   logic [2*WIDTH-1:0] res;

   // Single-cycle ops are evaluated straight from the inputs at the accepting edge
   always_comb begin
      sum    = {1'b0, A} + {1'b0, B};
      res_lo = '0;
      res_c  = 1'b0;
      case (Select)
         OP_ADD: begin res_lo = sum[WIDTH-1:0]; res_c = sum[WIDTH]; end
         OP_SUB: begin res_lo = A - B;          res_c = (A >= B);   end
         OP_AND: res_lo = A & B;
         OP_OR:  res_lo = A | B;
         OP_XOR: res_lo = A ^ B;
         OP_SHL: begin res_lo = {A[WIDTH-2:0], 1'b0}; res_c = A[WIDTH-1]; end
         OP_SHR: begin res_lo = {1'b0, A[WIDTH-1:1]}; res_c = A[0];       end
         default: begin res_lo = '0; res_c = 1'b0; end
      endcase
      res = {{WIDTH{1'b0}}, res_lo};
   end

   always_comb begin
      acc_next = acc;
      if (a_q[cnt])
         acc_next = acc + ({{WIDTH{1'b0}}, b_q} << cnt);
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state <= S_IDLE;
         a_q   <= '0;
         b_q   <= '0;
         acc   <= '0;
         cnt   <= '0;
         Sal   <= '0;
         Cout  <= 1'b0;
         Zero  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (Init) begin
                  a_q <= A;
                  b_q <= B;
                  if (Select == OP_MUL) begin
                     acc   <= '0;
                     cnt   <= '0;
                     state <= S_MUL;
                  end else begin
                     Sal   <= res;
                     Cout  <= res_c;
                     Zero  <= (res == '0);
                     state <= S_DONE;
                  end
               end
            end
            S_MUL: begin
               acc <= acc_next;
               cnt <= cnt + CW'(1);
               if (cnt == CNT_LAST) begin
                  Sal   <= acc_next;
                  Cout  <= 1'b0;
                  Zero  <= (acc_next == '0);
                  state <= S_DONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign Busy = (state != S_IDLE);
   assign Done = (state == S_DONE);
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq at WIDTH 4 and 8
module tb_alu_seq;
   logic Clk = 1'b0;
   logic Rst = 1'b0;

   logic        init4 = 1'b0;
   logic [3:0]  a4 = '0, b4 = '0;
   logic [2:0]  sel4 = '0;
   logic [7:0]  sal4;
   logic        cout4, zero4, busy4, done4;

   logic        init8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic [2:0]  sel8 = '0;
   logic [15:0] sal8;
   logic        cout8, zero8, busy8, done8;

   int n_chk = 0;
   int n_fail = 0;
   bit checking = 1'b0;

   // reference state per instance: index 0 is WIDTH=4, index 1 is WIDTH=8
   int          m_left [2];
   logic [15:0] p_sal [2];
   logic        p_c [2];
   logic [15:0] e_sal [2];
   logic        e_c [2];
   logic        e_z [2];

   alu_seq #(.WIDTH(4)) dut4 (
      .Clk(Clk), .Rst(Rst), .Init(init4), .A(a4), .B(b4), .Select(sel4),
      .Sal(sal4), .Cout(cout4), .Zero(zero4), .Busy(busy4), .Done(done4)
   );

   alu_seq #(.WIDTH(8)) dut8 (
      .Clk(Clk), .Rst(Rst), .Init(init8), .A(a8), .B(b8), .Select(sel8),
      .Sal(sal8), .Cout(cout8), .Zero(zero8), .Busy(busy8), .Done(done8)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int wk(input int k);
      return (k == 0) ? 4 : 8;
   endfunction

   // {cout, sal} from plain arithmetic
   function automatic logic [16:0] ref_op(input int w, input int a, input int b, input int s);
      int m;
      int sal;
      int c;
      m = 1 << w;
      c = 0;
      case (s)
         0: begin sal = (a + b) % m;     c = (a + b) / m;    end
         1: begin sal = (a - b + m) % m; c = (a >= b) ? 1 : 0; end
         2: sal = a * b;
         3: sal = a & b;
         4: sal = a | b;
         5: sal = a ^ b;
         6: begin sal = (a * 2) % m; c = (a / (m / 2)) % 2; end
         default: begin sal = a / 2; c = a % 2; end
      endcase
      return {c[0], sal[15:0]};
   endfunction

   task automatic mreset(input int k);
      m_left[k] = 0;
      p_sal[k] = '0; p_c[k] = 1'b0;
      e_sal[k] = '0; e_c[k] = 1'b0; e_z[k] = 1'b0;
   endtask

   // m_left counts remaining busy cycles; the result becomes visible with the Done cycle
   task automatic mstep(input int k, input bit init, input int a, input int b, input int s);
      logic [16:0] r;
      if (m_left[k] == 0) begin
         if (init) begin
            r = ref_op(wk(k), a, b, s);
            p_sal[k] = r[15:0];
            p_c[k] = r[16];
            m_left[k] = (s == 2) ? wk(k) + 1 : 1;
         end
      end else begin
         m_left[k]--;
      end
      if (m_left[k] == 1 && (init || m_left[k] != 0)) begin
         if (e_sal[k] !== p_sal[k] || 1'b1) begin
            e_sal[k] = p_sal[k];
            e_c[k] = p_c[k];
            e_z[k] = (p_sal[k] == 16'h0);
         end
      end
   endtask

   always @(posedge Clk or posedge Rst)
      if (Rst) mreset(0);
      else mstep(0, init4, int'(a4), int'(b4), int'(sel4));

   always @(posedge Clk or posedge Rst)
      if (Rst) mreset(1);
      else mstep(1, init8, int'(a8), int'(b8), int'(sel8));

   function automatic logic [15:0] g_sal(input int k);  return (k == 0) ? {8'h00, sal4} : sal8; endfunction
   function automatic logic g_cout(input int k);        return (k == 0) ? cout4 : cout8; endfunction
   function automatic logic g_zero(input int k);        return (k == 0) ? zero4 : zero8; endfunction
   function automatic logic g_busy(input int k);        return (k == 0) ? busy4 : busy8; endfunction
   function automatic logic g_done(input int k);        return (k == 0) ? done4 : done8; endfunction

   task automatic cmp(input int k);
      chk($sformatf("w%0d_sal", wk(k)),  32'(g_sal(k)),  32'(e_sal[k]));
      chk($sformatf("w%0d_cout", wk(k)), 32'(g_cout(k)), 32'(e_c[k]));
      chk($sformatf("w%0d_zero", wk(k)), 32'(g_zero(k)), 32'(e_z[k]));
      chk($sformatf("w%0d_busy", wk(k)), 32'(g_busy(k)), 32'(m_left[k] > 0));
      chk($sformatf("w%0d_done", wk(k)), 32'(g_done(k)), 32'(m_left[k] == 1));
   endtask

   always @(negedge Clk)
      if (checking) begin
         cmp(0);
         cmp(1);
      end

   task automatic drv(input int k, input bit i, input int a, input int b, input int s);
      if (k == 0) begin init4 = i; a4 = a[3:0]; b4 = b[3:0]; sel4 = s[2:0]; end
      else        begin init8 = i; a8 = a[7:0]; b8 = b[7:0]; sel8 = s[2:0]; end
   endtask

   // one operation; counts busy/done cycles until idle, optionally firing an Init mid-operation
   task automatic run(input int k, input int a, input int b, input int s, input bit glitch,
                      output int nb, output int nd);
      bit idle_seen;
      nb = 0; nd = 0; idle_seen = 1'b0;
      @(negedge Clk);
      drv(k, 1'b1, a, b, s);
      for (int i = 0; i < 40; i++) begin
         @(negedge Clk);
         if (i == 0) drv(k, 1'b0, int'($urandom), int'($urandom), int'($urandom_range(7)));
         if (glitch && i == 1) drv(k, 1'b1, 1, 1, 0);
         if (glitch && i == 2) drv(k, 1'b0, 1, 1, 0);
         if (g_busy(k)) nb++;
         if (g_done(k)) nd++;
         if (!g_busy(k)) begin
            idle_seen = 1'b1;
            break;
         end
      end
      if (!idle_seen) chk("op_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      int nb, nd;
      #1 Rst = 1'b1;
      checking = 1'b1;
      repeat (2) @(negedge Clk);
      chk("rst_sal", 32'(sal4), 32'h0);
      chk("rst_zero", 32'(zero4), 32'h0);
      chk("rst_busy", 32'(busy4), 32'h0);
      #2 Rst = 1'b0;

      run(0, 9, 8, 0, 1'b0, nb, nd);
      chk("add_busy_cycles", 32'(nb), 32'd1);
      chk("add_done_cycles", 32'(nd), 32'd1);
      chk("add_sal", 32'(sal4), 32'h01);
      chk("add_cout", 32'(cout4), 32'd1);
      chk("add_zero", 32'(zero4), 32'd0);

      run(0, 3, 5, 1, 1'b0, nb, nd);
      chk("sub_borrow_sal", 32'(sal4), 32'h0E);
      chk("sub_borrow_cout", 32'(cout4), 32'd0);
      run(0, 7, 7, 1, 1'b0, nb, nd);
      chk("sub_eq_sal", 32'(sal4), 32'h00);
      chk("sub_eq_cout", 32'(cout4), 32'd1);
      chk("sub_eq_zero", 32'(zero4), 32'd1);

      run(0, 15, 15, 2, 1'b1, nb, nd);
      chk("mul_busy_cycles", 32'(nb), 32'd5);
      chk("mul_done_cycles", 32'(nd), 32'd1);
      chk("mul_sal", 32'(sal4), 32'hE1);

      @(negedge Clk);
      drv(0, 1'b1, 6, 7, 2);
      @(negedge Clk);
      drv(0, 1'b0, 6, 7, 2);
      @(posedge Clk);
      @(posedge Clk);
      #2 Rst = 1'b1;
      #1;
      chk("arst_sal", 32'(sal4), 32'h0);
      chk("arst_busy", 32'(busy4), 32'h0);
      chk("arst_done", 32'(done4), 32'h0);
      @(negedge Clk);
      #2 Rst = 1'b0;
      run(0, 6, 7, 2, 1'b0, nb, nd);
      chk("mul_after_rst", 32'(sal4), 32'h2A);

      run(0, 10, 6, 3, 1'b0, nb, nd);
      chk("and_sal", 32'(sal4), 32'h02);
      chk("and_done", 32'(nd), 32'd1);
      run(0, 10, 6, 4, 1'b0, nb, nd);
      chk("or_sal", 32'(sal4), 32'h0E);
      run(0, 10, 6, 5, 1'b0, nb, nd);
      chk("xor_sal", 32'(sal4), 32'h0C);
      run(0, 10, 6, 6, 1'b0, nb, nd);
      chk("shl_sal", 32'(sal4), 32'h04);
      chk("shl_cout", 32'(cout4), 32'd1);
      run(0, 10, 6, 7, 1'b0, nb, nd);
      chk("shr_sal", 32'(sal4), 32'h05);
      chk("shr_cout", 32'(cout4), 32'd0);
      chk("shr_done", 32'(nd), 32'd1);

      run(1, 255, 255, 2, 1'b0, nb, nd);
      chk("w8_mul_busy_cycles", 32'(nb), 32'd9);
      chk("w8_mul_done_cycles", 32'(nd), 32'd1);
      chk("w8_mul_sal", 32'(sal8), 32'hFE01);
      run(1, 200, 100, 0, 1'b0, nb, nd);
      chk("w8_add_sal", 32'(sal8), 32'h002C);
      chk("w8_add_cout", 32'(cout8), 32'd1);

      for (int c = 0; c < 1500; c++) begin
         @(negedge Clk);
         drv(0, ($urandom_range(2) != 0), int'($urandom), int'($urandom), int'($urandom_range(7)));
         drv(1, ($urandom_range(3) == 0), int'($urandom), int'($urandom), int'($urandom_range(7)));
         if ($urandom_range(199) == 0) begin
            #2 Rst = 1'b1;
            @(negedge Clk);
            #2 Rst = 1'b0;
         end
      end
      drv(0, 1'b0, 0, 0, 0);
      drv(1, 1'b0, 0, 0, 0);
      repeat (12) @(negedge Clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
